// File: rtl/tail_light_pkg.sv
// Shared types and helpers for the rear-lamp sequencer.
package tail_light_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_SEQ, ST_ALARM} state_t;
  typedef enum logic [1:0] {DIR_LEFT, DIR_RIGHT, DIR_BOTH} dir_t;

  localparam int MAX_LAMPS = 32;

  // Lamps [s-1:0] lit, limited to the n lamps that exist on a side.
  function automatic logic [MAX_LAMPS-1:0] therm(input int s, input int n);
    logic [MAX_LAMPS-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_LAMPS; i++) begin
      r[i] = (i < s) && (i < n);
    end
    return r;
  endfunction

endpackage

// File: rtl/tail_light_sequencer_tick_divider.sv
// Step/blink time base: pulses tick once every TICK_DIV cycles.
module tick_divider #(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tail_light_sequencer.sv
// Rear-lamp controller: sequential turn indication, brake overlay and alarm blink.
module tail_light_sequencer
  import tail_light_pkg::*;
#(
  parameter int N_LAMPS  = 3,
  parameter int TICK_DIV = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               left,
  input  logic               right,
  input  logic               brake,
  input  logic               alarm,
  output logic [N_LAMPS-1:0] left_lamps,
  output logic [N_LAMPS-1:0] right_lamps,
  output logic               busy
);

  localparam int SW = $clog2(N_LAMPS + 1);

  state_t             state, state_nx;
  dir_t               dir, dir_nx;
  logic [SW-1:0]      s, s_nx;
  logic               blink, blink_nx;
  logic               tick, clr, req_active;
  logic [N_LAMPS-1:0] left_nx, right_nx, seq_pat, brk_pat;

  // Counter restarts on every state change and is parked while idle.
  assign clr = (state_nx != state) || (state == ST_IDLE);

  tick_divider #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .reset(reset),
    .clr  (clr),
    .tick (tick)
  );

  always_comb begin
    case (dir)
      DIR_LEFT:  req_active = left;
      DIR_RIGHT: req_active = right;
      default:   req_active = left && right;
    endcase
  end

  always_comb begin
    state_nx = state;
    dir_nx   = dir;
    s_nx     = s;
    blink_nx = blink;
    if (alarm) begin
      if (state != ST_ALARM) begin
        state_nx = ST_ALARM;
        blink_nx = 1'b1;
        s_nx     = '0;
      end else if (tick) begin
        blink_nx = ~blink;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (left || right) begin
            state_nx = ST_SEQ;
            s_nx     = SW'(1);
            dir_nx   = (left && right) ? DIR_BOTH : (left ? DIR_LEFT : DIR_RIGHT);
          end
        end
        ST_SEQ: begin
          if (tick) begin
            if (s == '0) begin
              if (req_active) s_nx = SW'(1);
              else            state_nx = ST_IDLE;
            end else if (s == SW'(N_LAMPS)) begin
              s_nx = '0;
            end else begin
              s_nx = s + 1'b1;
            end
          end
        end
        default: begin
          state_nx = ST_IDLE;
          s_nx     = '0;
          blink_nx = 1'b0;
        end
      endcase
    end

    // Lamp drives are computed from next-state so they settle on the same edge.
    seq_pat  = N_LAMPS'(therm(int'(s_nx), N_LAMPS));
    brk_pat  = brake ? '1 : '0;
    left_nx  = '0;
    right_nx = '0;
    case (state_nx)
      ST_IDLE: begin
        left_nx  = brk_pat;
        right_nx = brk_pat;
      end
      ST_SEQ: begin
        case (dir_nx)
          DIR_LEFT: begin
            left_nx  = seq_pat;
            right_nx = brk_pat;
          end
          DIR_RIGHT: begin
            left_nx  = brk_pat;
            right_nx = seq_pat;
          end
          default: begin
            left_nx  = seq_pat;
            right_nx = seq_pat;
          end
        endcase
      end
      default: begin
        left_nx  = blink_nx ? '1 : '0;
        right_nx = blink_nx ? '1 : '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      dir         <= DIR_LEFT;
      s           <= '0;
      blink       <= 1'b0;
      left_lamps  <= '0;
      right_lamps <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nx;
      dir         <= dir_nx;
      s           <= s_nx;
      blink       <= blink_nx;
      left_lamps  <= left_nx;
      right_lamps <= right_nx;
      busy        <= (state_nx != ST_IDLE);
    end
  end

endmodule

// File: doc/tail_light_sequencer.md
Name: tail_light_sequencer

Overview:
- Parametrised rear-lamp controller. Each side has N_LAMPS lamps; the block drives both sides.
- Supports sequential turn indication (left, right, or both sides in sync), a brake overlay and an alarm blink.
- Step timing comes from an internal tick divider, so the block runs directly on the system clock.
- Sits between the driver-input debounce logic and the lamp drivers.

Parameters:
- N_LAMPS, 3, lamps per side (≥1); index 0 is the innermost lamp.
- TICK_DIV, 1, clock cycles per sequence step / blink phase (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- left  in  1  left turn request, level.
- right  in  1  right turn request, level.
- brake  in  1  brake pedal, level.
- alarm  in  1  alarm request, level.
- left_lamps  out  N_LAMPS  left lamp drives, registered.
- right_lamps  out  N_LAMPS  right lamp drives, registered.
- busy  out  1  1 when the FSM is not in IDLE, registered.

Behaviour:
- Reset and clocking (already decided):
  - One clock, clk; reset is asynchronous and active-high.
  - On reset assertion, immediately and regardless of clk: all lamps 0, busy 0, FSM in IDLE, step counter 0, tick counter 0, blink 0.
- State:
  - FSM states: IDLE, SEQ, ALARM.
  - Latched direction dir ∈ {LEFT, RIGHT, BOTH}.
  - Step counter s, width $clog2(N_LAMPS+1).
  - Tick counter, width max(1, $clog2(TICK_DIV)). It asserts tick when count == TICK_DIV-1, then wraps to 0.
  - The tick counter is cleared on every state change and held at 0 in IDLE.
- Priority at every edge: alarm > turn start > brake.
- IDLE:
  - alarm=1 → ALARM, blink=1.
  - Else left|right → SEQ with s=1. dir = BOTH if both requests are high, else LEFT or RIGHT.
  - This transition is not tick-gated; it happens on the sampling edge.
- SEQ:
  - Transitions only on tick.
  - If s<N_LAMPS, s ← s+1.
  - If s==N_LAMPS, s ← 0 (dark phase).
  - At the tick ending s==0: if the request matching dir is still active (BOTH needs left&right), s ← 1; otherwise → IDLE.
  - Request changes during a sequence are ignored until the dark-phase tick.
  - Sequenced side output: thermometer code of s (lamps [s-1:0] lit). For BOTH, both sides show the same pattern.
  - Cycle period: (N_LAMPS+1)·TICK_DIV cycles.
- ALARM:
  - Entered from any state on the edge alarm=1 is sampled. Any sequence is aborted and the tick counter cleared.
  - blink toggles on each tick; both sides all-ones when blink=1, all-zeros when blink=0.
  - alarm=0 sampled → IDLE on that edge.
  - brake is ignored in ALARM.
- Brake overlay:
  - In IDLE, brake=1 makes both sides all-ones.
  - In SEQ with dir LEFT or RIGHT, brake=1 makes the non-sequenced side all-ones.
  - In SEQ with dir BOTH, brake has no effect.
  - Latency is 1 edge: outputs are registered from next-state values.
- busy = (next state != IDLE), registered.
- Output latency: lamps reflect the state entered at the same edge. Example: left sampled at edge E → left_lamps[0]=1 after E.

Decomposition:
- tail_light_pkg holds:
  - state_t enum {ST_IDLE, ST_SEQ, ST_ALARM};
  - dir_t enum {DIR_LEFT, DIR_RIGHT, DIR_BOTH};
  - a thermometer-encode function therm(s, N).
- Sub-module tick_divider (parameter TICK_DIV; inputs clk, reset, clr; output tick) owns the tick counter.

Test Plan (N_LAMPS=3, TICK_DIV=2, E0 = edge sampling the stimulus):
- Left pulse, one cycle → left_lamps = 001 @E0, 011 @E0+2, 111 @E0+4, 000 @E0+6. IDLE at E0+8 with busy 0; right_lamps 000 throughout.
- Right held 20 cycles → pattern 001/011/111/000 repeats with period 8 cycles. After the release the current cycle completes, then IDLE.
- left and right raised on the same edge → both sides show identical thermometer steps. Dropping only left mid-sequence → still BOTH until the dark-phase tick, then IDLE.
- Brake during a left sequence → right_lamps = 111 one edge after brake rises and 000 one edge after it falls; left pattern unaffected. Brake in IDLE → both sides 111.
- alarm raised at s=2 of a right sequence → both sides 111 @E0, 000 @E0+2, 111 @E0+4. alarm drop with brake=0 → both 000 on the next edge, busy 0.
- reset asserted mid-cycle during SEQ (s=3) → all outputs 0 immediately, before the next clk edge. After release with right=1 → sequence restarts at 001.
